// File: rtl/rat_pc_stack.sv
// Program-flow unit: PC sequencing, circular return-address stack and
// single-level interrupt entry/exit with a C/Z shadow. All outputs are registered.
module rat_pc_stack #(
   parameter int                ADDR_W    = 10,
   parameter int                DEPTH     = 8,
   parameter logic [ADDR_W-1:0] RESET_VEC = 10'h000,
   parameter logic [ADDR_W-1:0] INT_VEC   = 10'h3FF
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [2:0]                   PC_OP,
   input  logic [ADDR_W-1:0]            BR_ADDR,
   input  logic                         INT_REQ,
   input  logic                         I_SET,
   input  logic                         I_CLR,
   input  logic                         C_IN,
   input  logic                         Z_IN,
   output logic [ADDR_W-1:0]            PC_COUNT,
   output logic                         INT_EN,
   output logic                         INT_ACK,
   output logic                         C_SHAD,
   output logic                         Z_SHAD,
   output logic                         FLG_SHAD_LD,
   output logic [$clog2(DEPTH+1)-1:0]   STK_CNT,
   output logic                         STK_OVF,
   output logic                         STK_UDF
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_INC   = 3'b001;
   localparam logic [2:0] OP_JMP   = 3'b010;
   localparam logic [2:0] OP_CALL  = 3'b011;
   localparam logic [2:0] OP_RET   = 3'b100;
   localparam logic [2:0] OP_RETIE = 3'b101;
   localparam logic [2:0] OP_RETID = 3'b110;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              int_en_q, int_en_d;
   logic              ack_q, ack_d;
   logic              c_shad_q, c_shad_d;
   logic              z_shad_q, z_shad_d;
   logic              flg_ld_q, flg_ld_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     top_q, top_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic [ADDR_W-1:0] mem_q [DEPTH];

   logic [ADDR_W-1:0] npc_s;
   logic [ADDR_W-1:0] push_val_s;
   logic              take_s;
   logic              push_s;
   logic              pop_s;

   // Wrapping pointer helpers; storage need not be a power of two deep.
   function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
      if (p == IW'(DEPTH - 1)) return IW'(0);
      else                     return p + IW'(1);
   endfunction

   function automatic logic [IW-1:0] ptr_dec(input logic [IW-1:0] p);
      if (p == IW'(0)) return IW'(DEPTH - 1);
      else             return p - IW'(1);
   endfunction

   // Next-state computation for PC, stack bookkeeping, enable and pulses.
   always_comb begin
      pc_d       = pc_q;
      int_en_d   = int_en_q;
      c_shad_d   = c_shad_q;
      z_shad_d   = z_shad_q;
      cnt_d      = cnt_q;
      top_d      = top_q;
      ovf_d      = ovf_q;
      udf_d      = udf_q;
      npc_s      = pc_q;
      pop_s      = 1'b0;
      push_s     = 1'b0;
      push_val_s = pc_q + ADDR_W'(1);

      case (PC_OP)
         OP_INC:  npc_s = pc_q + ADDR_W'(1);
         OP_JMP:  npc_s = BR_ADDR;
         OP_CALL: begin
            npc_s  = BR_ADDR;
            push_s = 1'b1;
         end
         OP_RET, OP_RETIE, OP_RETID: begin
            pop_s = 1'b1;
            if (cnt_q == CW'(0)) npc_s = RESET_VEC;
            else                 npc_s = mem_q[ptr_dec(top_q)];
         end
         default: npc_s = pc_q;
      endcase

      take_s   = int_en_q & INT_REQ & ((PC_OP == OP_INC) | (PC_OP == OP_JMP));
      ack_d    = take_s;
      flg_ld_d = (PC_OP == OP_RETIE) | (PC_OP == OP_RETID);

      // The interrupt pushes the address the op would have gone to.
      if (take_s) begin
         push_s     = 1'b1;
         push_val_s = npc_s;
         pc_d       = INT_VEC;
         c_shad_d   = C_IN;
         z_shad_d   = Z_IN;
      end else begin
         pc_d = npc_s;
      end

      if (push_s) begin
         top_d = ptr_inc(top_q);
         if (cnt_q == CW'(DEPTH)) ovf_d = 1'b1;
         else                     cnt_d = cnt_q + CW'(1);
      end else if (pop_s) begin
         if (cnt_q == CW'(0)) begin
            udf_d = 1'b1;
         end else begin
            top_d = ptr_dec(top_q);
            cnt_d = cnt_q - CW'(1);
         end
      end else begin
         top_d = top_q;
      end

      if (take_s)                  int_en_d = 1'b0;
      else if (I_CLR)              int_en_d = 1'b0;
      else if (I_SET)              int_en_d = 1'b1;
      else if (PC_OP == OP_RETIE)  int_en_d = 1'b1;
      else if (PC_OP == OP_RETID)  int_en_d = 1'b0;
      else                         int_en_d = int_en_q;
   end

   // Control/status registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pc_q     <= RESET_VEC;
         int_en_q <= 1'b0;
         ack_q    <= 1'b0;
         c_shad_q <= 1'b0;
         z_shad_q <= 1'b0;
         flg_ld_q <= 1'b0;
         cnt_q    <= CW'(0);
         top_q    <= IW'(0);
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         int_en_q <= int_en_d;
         ack_q    <= ack_d;
         c_shad_q <= c_shad_d;
         z_shad_q <= z_shad_d;
         flg_ld_q <= flg_ld_d;
         cnt_q    <= cnt_d;
         top_q    <= top_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Stack storage; contents are don't-care after reset.
   always_ff @(posedge CLK) begin
      if (push_s && !RST) begin
         mem_q[top_q] <= push_val_s;
      end
   end

   assign PC_COUNT    = pc_q;
   assign INT_EN      = int_en_q;
   assign INT_ACK     = ack_q;
   assign C_SHAD      = c_shad_q;
   assign Z_SHAD      = z_shad_q;
   assign FLG_SHAD_LD = flg_ld_q;
   assign STK_CNT     = cnt_q;
   assign STK_OVF     = ovf_q;
   assign STK_UDF     = udf_q;
endmodule

// File: tb/tb_rat_pc_stack.sv
// Bench for rat_pc_stack: queue-based reference model checked every cycle,
// directed test-plan sequences with literal expectations, then random stimulus.
module tb_rat_pc_stack;
   localparam int ADDR_W = 10;
   localparam int DEPTH  = 8;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] RVEC = 10'h000;
   localparam logic [ADDR_W-1:0] IVEC = 10'h3FF;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [2:0]        PC_OP = 3'b000;
   logic [ADDR_W-1:0] BR_ADDR = '0;
   logic              INT_REQ = 1'b0, I_SET = 1'b0, I_CLR = 1'b0, C_IN = 1'b0, Z_IN = 1'b0;
   logic [ADDR_W-1:0] PC_COUNT;
   logic              INT_EN, INT_ACK, C_SHAD, Z_SHAD, FLG_SHAD_LD, STK_OVF, STK_UDF;
   logic [CW-1:0]     STK_CNT;

   rat_pc_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VEC(RVEC), .INT_VEC(IVEC)) dut (
      .CLK(CLK), .RST(RST), .PC_OP(PC_OP), .BR_ADDR(BR_ADDR), .INT_REQ(INT_REQ),
      .I_SET(I_SET), .I_CLR(I_CLR), .C_IN(C_IN), .Z_IN(Z_IN),
      .PC_COUNT(PC_COUNT), .INT_EN(INT_EN), .INT_ACK(INT_ACK), .C_SHAD(C_SHAD),
      .Z_SHAD(Z_SHAD), .FLG_SHAD_LD(FLG_SHAD_LD), .STK_CNT(STK_CNT),
      .STK_OVF(STK_OVF), .STK_UDF(STK_UDF));

   always #5 CLK = ~CLK;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit chk_en = 1'b0;

   // Reference model state
   logic [ADDR_W-1:0] m_pc = RVEC;
   logic [ADDR_W-1:0] m_stk[$];
   bit m_en = 0, m_ack = 0, m_c = 0, m_z = 0, m_flg = 0, m_ovf = 0, m_udf = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h at %0t", nm, got, exp, $time);
   endtask

   task automatic model_push(input logic [ADDR_W-1:0] v);
      m_stk.push_back(v);
      if (m_stk.size() > DEPTH) begin
         void'(m_stk.pop_front());
         m_ovf = 1;
      end
   endtask

   always @(posedge CLK) begin
      logic [ADDR_W-1:0] npc;
      bit take;
      if (RST) begin
         m_pc = RVEC; m_stk.delete();
         m_en = 0; m_ack = 0; m_c = 0; m_z = 0; m_flg = 0; m_ovf = 0; m_udf = 0;
      end else begin
         npc = m_pc;
         if (PC_OP == 3'd1) npc = m_pc + 10'd1;
         else if (PC_OP == 3'd2) npc = BR_ADDR;
         else if (PC_OP == 3'd3) begin
            model_push(m_pc + 10'd1);
            npc = BR_ADDR;
         end else if (PC_OP >= 3'd4 && PC_OP <= 3'd6) begin
            if (m_stk.size() == 0) begin
               npc = RVEC; m_udf = 1;
            end else npc = m_stk.pop_back();
         end
         take = m_en && INT_REQ && (PC_OP == 3'd1 || PC_OP == 3'd2);
         m_flg = (PC_OP == 3'd5 || PC_OP == 3'd6);
         m_ack = take;
         if (PC_OP == 3'd5) m_en = 1;
         if (PC_OP == 3'd6) m_en = 0;
         if (I_SET) m_en = 1;
         if (I_CLR) m_en = 0;
         if (take) begin
            model_push(npc);
            npc = IVEC; m_en = 0; m_c = C_IN; m_z = Z_IN;
         end
         m_pc = npc;
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("pc", 32'(PC_COUNT), 32'(m_pc));
         chk("int_en", 32'(INT_EN), 32'(m_en));
         chk("int_ack", 32'(INT_ACK), 32'(m_ack));
         chk("c_shad", 32'(C_SHAD), 32'(m_c));
         chk("z_shad", 32'(Z_SHAD), 32'(m_z));
         chk("flg_ld", 32'(FLG_SHAD_LD), 32'(m_flg));
         chk("stk_cnt", 32'(STK_CNT), 32'(m_stk.size()));
         chk("stk_ovf", 32'(STK_OVF), 32'(m_ovf));
         chk("stk_udf", 32'(STK_UDF), 32'(m_udf));
      end
   end

   // Literal expectation applied to both DUT and model.
   task automatic lit(input string nm, input logic [31:0] dv, input logic [31:0] mv,
                      input logic [31:0] exp);
      total_cnt++;
      if (dv === exp && mv === exp) pass_cnt++;
      else $display("FAIL %s: dut %0h model %0h, want %0h", nm, dv, mv, exp);
   endtask

   task automatic step(input logic [2:0] op, input logic [ADDR_W-1:0] br, input logic req,
                       input logic is, input logic ic, input logic c, input logic z,
                       input logic rst);
      PC_OP = op; BR_ADDR = br; INT_REQ = req; I_SET = is; I_CLR = ic;
      C_IN = c; Z_IN = z; RST = rst;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic op(input logic [2:0] o, input logic [ADDR_W-1:0] br);
      step(o, br, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [ADDR_W-1:0] e;
      step(3'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(3'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_en = 1'b1;
      lit("reset_pc", 32'(PC_COUNT), 32'(m_pc), 32'h0);
      for (int i = 1; i <= 5; i++) begin
         op(3'd1, '0);
         lit("inc_pc", 32'(PC_COUNT), 32'(m_pc), 32'(i));
      end
      op(3'd2, 10'h3FF);
      op(3'd1, '0);
      lit("wrap_pc", 32'(PC_COUNT), 32'(m_pc), 32'h0);
      lit("status_clear", 32'({STK_CNT, INT_EN, STK_OVF, STK_UDF, INT_ACK}),
          32'({m_stk.size() != 0, m_en, m_ovf, m_udf, m_ack}), 32'h0);

      op(3'd2, 10'h005);
      op(3'd3, 10'h020);
      lit("call1_pc", 32'(PC_COUNT), 32'(m_pc), 32'h020);
      op(3'd1, '0);
      op(3'd3, 10'h040);
      lit("call2_cnt", 32'(STK_CNT), 32'(m_stk.size()), 32'd2);
      op(3'd4, '0);
      lit("ret1_pc", 32'(PC_COUNT), 32'(m_pc), 32'h022);
      op(3'd4, '0);
      lit("ret2_pc", 32'(PC_COUNT), 32'(m_pc), 32'h006);

      op(3'd2, 10'h000);
      for (int i = 1; i <= 9; i++) op(3'd3, ADDR_W'(i));
      lit("ovf_flag", 32'(STK_OVF), 32'(m_ovf), 32'h1);
      lit("ovf_cnt", 32'(STK_CNT), 32'(m_stk.size()), 32'd8);
      for (int i = 9; i >= 2; i--) begin
         op(3'd4, '0);
         lit("ovf_ret_pc", 32'(PC_COUNT), 32'(m_pc), 32'(i));
      end
      op(3'd4, '0);
      lit("udf_pc", 32'(PC_COUNT), 32'(m_pc), 32'(RVEC));
      lit("udf_flag", 32'(STK_UDF), 32'(m_udf), 32'h1);

      op(3'd2, 10'h010);
      step(3'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(3'd1, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      lit("int_pc", 32'(PC_COUNT), 32'(m_pc), 32'h3FF);
      lit("int_ack", 32'(INT_ACK), 32'(m_ack), 32'h1);
      lit("int_cshad", 32'(C_SHAD), 32'(m_c), 32'h1);
      lit("int_cnt", 32'(STK_CNT), 32'(m_stk.size()), 32'd1);
      op(3'd5, '0);
      lit("retie_pc", 32'(PC_COUNT), 32'(m_pc), 32'h011);
      lit("retie_flg", 32'(FLG_SHAD_LD), 32'(m_flg), 32'h1);
      lit("retie_en", 32'(INT_EN), 32'(m_en), 32'h1);

      step(3'd3, 10'h080, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      lit("defer_pc", 32'(PC_COUNT), 32'(m_pc), 32'h080);
      lit("defer_ack", 32'(INT_ACK), 32'(m_ack), 32'h0);
      step(3'd1, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      lit("defer_take", 32'(PC_COUNT), 32'(m_pc), 32'h3FF);
      lit("defer_cnt", 32'(STK_CNT), 32'(m_stk.size()), 32'd2);
      e = m_stk[m_stk.size()-1];
      lit("defer_push", 32'(e), 32'(e), 32'h081);

      step(3'd0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      lit("set_clr_en", 32'(INT_EN), 32'(m_en), 32'h0);
      step(3'd0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(3'd1, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      lit("rst_take_pc", 32'(PC_COUNT), 32'(m_pc), 32'(RVEC));
      lit("rst_take_cnt", 32'(STK_CNT), 32'(m_stk.size()), 32'd0);
      lit("rst_take_ack", 32'(INT_ACK), 32'(m_ack), 32'h0);
      op(3'd0, '0);
      lit("rst_take_ack2", 32'(INT_ACK), 32'(m_ack), 32'h0);

      for (int n = 0; n < 3000; n++) begin
         int r;
         logic [2:0] o;
         r = $urandom_range(0, 99);
         if (r < 35) o = 3'd1;
         else if (r < 50) o = 3'd2;
         else if (r < 68) o = 3'd3;
         else if (r < 80) o = 3'd4;
         else if (r < 85) o = 3'd5;
         else if (r < 90) o = 3'd6;
         else if (r < 95) o = 3'd0;
         else o = 3'd7;
         step(o, ADDR_W'($urandom), ($urandom_range(0, 99) < 35),
              ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 5),
              1'($urandom), 1'($urandom), ($urandom_range(0, 299) == 0));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
